// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_updown_counter
// Purpose  : Modulo-MODULUS up/down counter with enable, clear, clamped load,
//            optional saturation, end-crossing event pulse and AT_END flag.
// Revision : 1.0  initial release
// ============================================================================
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    input  logic             EN,
    input  logic             DIR,
    output logic [WIDTH-1:0] COUNT,
    output logic             EVENT,
    output logic             AT_END
);

    localparam logic [WIDTH:0] c_MOD = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0] c_MAX = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH:0] c_ONE = (WIDTH + 1)'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             event_q;
    logic             event_d;

    logic [WIDTH:0]   w_count_ext;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH:0]   w_din_ext;
    logic             w_at_max;
    logic             w_at_zero;

    // One extra bit keeps the top-end compare and the bottom-end borrow
    // exact even when MODULUS equals 2^WIDTH.
    assign w_count_ext = {1'b0, count_q};
    assign w_din_ext   = {1'b0, DIN};
    assign w_inc       = w_count_ext + c_ONE;
    assign w_dec       = w_count_ext - c_ONE;
    assign w_at_max    = (w_inc == c_MOD);
    assign w_at_zero   = w_dec[WIDTH];

    always_comb begin
        count_d = count_q;
        event_d = 1'b0;
        if (CLR) begin
            count_d = '0;
        end else if (LOAD) begin
            if (w_din_ext > c_MAX) begin
                count_d = c_MAX[WIDTH-1:0];
            end else begin
                count_d = DIN;
            end
        end else if (EN) begin
            if (DIR) begin
                if (w_at_max) begin
                    event_d = 1'b1;
                    if (!SATURATE) begin
                        count_d = '0;
                    end
                end else begin
                    count_d = w_inc[WIDTH-1:0];
                end
            end else begin
                if (w_at_zero) begin
                    event_d = 1'b1;
                    if (!SATURATE) begin
                        count_d = c_MAX[WIDTH-1:0];
                    end
                end else begin
                    count_d = w_dec[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
            event_q <= 1'b0;
        end else begin
            count_q <= count_d;
            event_q <= event_d;
        end
    end

    assign COUNT  = count_q;
    assign EVENT  = event_q;
    assign AT_END = DIR ? w_at_max : w_at_zero;

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_updown_counter
// Purpose  : Scoreboard bench for mod_updown_counter (wrap, saturate, cascade).
// Revision : 1.0  initial release
// ============================================================================
module tb_mod_updown_counter;

    typedef struct {
        int    id;
        int    count;
        logic  ev;
        logic  at;
        string nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       a_clr = 0, a_load = 0, a_en = 0, a_dir = 0;
    logic [3:0] a_din = '0;
    logic [3:0] a_count;
    logic       a_event, a_at_end;

    logic       s_clr = 0, s_load = 0, s_en = 0, s_dir = 0;
    logic [3:0] s_din = '0;
    logic [3:0] s_count;
    logic       s_event, s_at_end;

    logic       c_en = 0;
    logic [3:0] lo_count, hi_count;
    logic       lo_event, lo_at_end, hi_event, hi_at_end;
    logic       w_hi_en;

    int   checks = 0;
    int   failures = 0;
    int   hi_pulses = 0;
    logic casc_phase = 1'b0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    assign w_hi_en = lo_at_end & c_en;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_a (
        .CLK(clk), .RST_N(rst_n), .CLR(a_clr), .LOAD(a_load), .DIN(a_din),
        .EN(a_en), .DIR(a_dir), .COUNT(a_count), .EVENT(a_event), .AT_END(a_at_end));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_s (
        .CLK(clk), .RST_N(rst_n), .CLR(s_clr), .LOAD(s_load), .DIN(s_din),
        .EN(s_en), .DIR(s_dir), .COUNT(s_count), .EVENT(s_event), .AT_END(s_at_end));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_lo (
        .CLK(clk), .RST_N(rst_n), .CLR(1'b0), .LOAD(1'b0), .DIN(4'd0),
        .EN(c_en), .DIR(1'b1), .COUNT(lo_count), .EVENT(lo_event), .AT_END(lo_at_end));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_hi (
        .CLK(clk), .RST_N(rst_n), .CLR(1'b0), .LOAD(1'b0), .DIN(4'd0),
        .EN(w_hi_en), .DIR(1'b1), .COUNT(hi_count), .EVENT(hi_event), .AT_END(hi_at_end));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Monitor: each queued expectation describes the state after the next edge.
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            case (mon_e.id)
                0: begin
                    chk({mon_e.nm, ".count"}, int'(a_count), mon_e.count);
                    chk({mon_e.nm, ".event"}, int'(a_event), int'(mon_e.ev));
                    chk({mon_e.nm, ".at_end"}, int'(a_at_end), int'(mon_e.at));
                end
                1: begin
                    chk({mon_e.nm, ".count"}, int'(s_count), mon_e.count);
                    chk({mon_e.nm, ".event"}, int'(s_event), int'(mon_e.ev));
                    chk({mon_e.nm, ".at_end"}, int'(s_at_end), int'(mon_e.at));
                end
                default: begin
                    chk({mon_e.nm, ".count"}, int'({hi_count, lo_count}), mon_e.count);
                    chk({mon_e.nm, ".hi_event"}, int'(hi_event), int'(mon_e.ev));
                    chk({mon_e.nm, ".lo_at_end"}, int'(lo_at_end), int'(mon_e.at));
                end
            endcase
        end
        if (casc_phase && hi_event) hi_pulses++;
    end

    task automatic step(input int id, input logic clr, input logic load, input logic [3:0] din,
                        input logic en, input logic dir, input int ec, input logic eev,
                        input logic eat, input string nm);
        exp_t e;
        @(negedge clk);
        a_clr = 0; a_load = 0; a_en = 0;
        s_clr = 0; s_load = 0; s_en = 0;
        c_en  = 0;
        if (id == 0) begin
            a_clr = clr; a_load = load; a_din = din; a_en = en; a_dir = dir;
        end else if (id == 1) begin
            s_clr = clr; s_load = load; s_din = din; s_en = en; s_dir = dir;
        end else begin
            c_en = en;
        end
        e.id = id; e.count = ec; e.ev = eev; e.at = eat; e.nm = nm;
        q.push_back(e);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("reset.count", int'(a_count), 0);
        chk("reset.event", int'(a_event), 0);
        chk("reset.at_end_down_at_zero", int'(a_at_end), 1);
        chk("reset.s_count", int'(s_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap up through 9 -> 0 -> 2
        for (int i = 1; i <= 12; i++)
            step(0, 0, 0, 4'd0, 1, 1, i % 10, (i == 10), ((i % 10) == 9), $sformatf("up%0d", i));

        // Down from 0 wraps to 9
        step(0, 0, 1, 4'd0, 0, 0, 0, 0, 1, "load0");
        step(0, 0, 0, 4'd0, 1, 0, 9, 1, 0, "down_wrap");
        step(0, 0, 0, 4'd0, 1, 0, 8, 0, 0, "down8");
        step(0, 0, 0, 4'd0, 1, 0, 7, 0, 0, "down7");

        // Load clamp and priority
        step(0, 0, 1, 4'd13, 0, 1, 9, 0, 1, "load13_clamp");
        step(0, 0, 1, 4'd5,  0, 1, 5, 0, 0, "load5");
        step(0, 0, 1, 4'd15, 0, 0, 9, 0, 0, "load15_clamp");
        step(0, 1, 1, 4'd3,  0, 1, 0, 0, 0, "clr_over_load");
        step(0, 0, 1, 4'd7,  1, 1, 7, 0, 0, "load_over_en");
        step(0, 0, 0, 4'd0,  0, 1, 7, 0, 0, "hold");
        step(0, 0, 0, 4'd0,  1, 0, 6, 0, 0, "down6");

        // Saturating instance
        for (int i = 1; i <= 9; i++)
            step(1, 0, 0, 4'd0, 1, 1, i, 0, (i == 9), $sformatf("sat_up%0d", i));
        for (int i = 1; i <= 3; i++)
            step(1, 0, 0, 4'd0, 1, 1, 9, 1, 1, $sformatf("sat_block%0d", i));
        step(1, 0, 0, 4'd0, 1, 0, 8, 0, 0, "sat_down8");
        step(1, 0, 1, 4'd1, 0, 0, 1, 0, 0, "sat_load1");
        step(1, 0, 0, 4'd0, 1, 0, 0, 0, 1, "sat_down0");
        step(1, 0, 0, 4'd0, 1, 0, 0, 1, 1, "sat_block_low");
        step(1, 0, 0, 4'd0, 0, 0, 0, 0, 1, "sat_idle");

        // Asynchronous reset mid-cycle: A sits at 6 here
        step(0, 0, 0, 4'd0, 1, 1, 7, 0, 0, "up7");
        step(0, 0, 0, 4'd0, 1, 0, 6, 0, 0, "back6");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst.count", int'(a_count), 0);
        chk("async_rst.event", int'(a_event), 0);
        a_en = 1; a_dir = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_held.count", int'(a_count), 0);
        @(negedge clk);
        a_en = 0;
        rst_n = 1'b1;
        step(0, 0, 0, 4'd0, 1, 1, 1, 0, 0, "first_after_rst");

        // Cascade from a fresh reset
        @(negedge clk);
        a_en = 0; s_en = 0; c_en = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        casc_phase = 1'b1;
        for (int i = 1; i <= 100; i++)
            step(2, 0, 0, 4'd0, 1, 1, ((i / 10) % 10) * 16 + (i % 10), (i == 100),
                 ((i % 10) == 9), $sformatf("casc%0d", i));
        @(negedge clk);
        c_en = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("casc.hi_pulses", hi_pulses, 1);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
